bounce_gen: RTL and testbench

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen.sv | 110 +++++++++++
 tb/tb_bounce_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// bounce_gen: emulated mechanical switch that bounces for a fixed window before settling
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   request one bounce sequence (ignored while busy or on the done cycle)
//   level      in   settled switch level, captured with an accepted start
//   sw         out  bouncy switch signal
//   busy       out  high for exactly BOUNCE_CYC cycles per sequence
//   done_tick  out  one-cycle pulse after the window expires
//   bounce_cnt out  sw transitions in the current/last sequence, saturating at 255
module bounce_gen #(
    parameter int          BOUNCE_CYC = 100000,
    parameter int          GAP_BITS   = 10,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       level,
    output logic       sw,
    output logic       busy,
    output logic       done_tick,
    output logic [7:0] bounce_cnt
);
    localparam int          WW      = $clog2(BOUNCE_CYC);
    localparam int          GW      = GAP_BITS + 1;
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  BOUNCE  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          sw_q, sw_d, busy_q, busy_d, done_q, done_d, target_q, target_d;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [WW-1:0] win_q, win_d;
    logic [GW-1:0] gap_q, gap_d, g;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
    assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign g       = GW'(lfsr_q[GAP_BITS-1:0]) + GW'(1);
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        win_d    = win_q;
        gap_d    = gap_q;
        target_d = target_q;
        if (state_q == IDLE) begin
            // done_q blocks a start landing on the completion cycle
            if (start && !done_q) begin
                state_d  = BOUNCE;
                busy_d   = 1'b1;
                target_d = level;
                cnt_d    = 8'd0;
                win_d    = WW'(BOUNCE_CYC - 1);
                gap_d    = g;
            end
        end else begin
            win_d = win_q - WW'(1);
            gap_d = gap_q - GW'(1);
            if (win_q == '0) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                sw_d    = target_q;
                cnt_d   = (target_q != sw_q) ? cnt_inc : cnt_q;
                win_d   = '0;
                gap_d   = '0;
            end else if (gap_q == GW'(1)) begin
                sw_d  = ~sw_q;
                gap_d = g;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 8'd0;
            lfsr_q   <= SEED_NZ;
            win_q    <= '0;
            gap_q    <= '0;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            win_q    <= win_d;
            gap_q    <= gap_d;
            target_q <= target_d;
        end
    end

    assign sw         = sw_q;
    assign busy       = busy_q;
    assign done_tick  = done_q;
    assign bounce_cnt = cnt_q;
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed checks of bounce_gen timing, toggling, reset and saturation
module tb_bounce_gen;
    logic       clk = 1'b0;
    logic       rst_a, start_a, level_a, sw_a, busy_a, done_a;
    logic [7:0] cnt_a;
    logic       rst_b, start_b, level_b, sw_b, busy_b, done_b;
    logic [7:0] cnt_b;
    logic [15:0] m_lfsr;
    logic       wave [0:64];
    int         errors = 0;
    int         checks = 0;

    bounce_gen #(.BOUNCE_CYC(64), .GAP_BITS(3)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .level(level_a),
        .sw(sw_a), .busy(busy_a), .done_tick(done_a), .bounce_cnt(cnt_a)
    );

    bounce_gen #(.BOUNCE_CYC(1000), .GAP_BITS(1)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .level(level_b),
        .sw(sw_b), .busy(busy_b), .done_tick(done_b), .bounce_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // Reference LFSR for dut_a: x^16+x^14+x^13+x^11+1, seed ACE1
    always @(posedge clk)
        m_lfsr <= rst_a ? 16'hACE1 : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Runs one sequence on dut_a starting at a negedge with the DUT idle.
    // Sample index s counts posedges after the accepting edge (s=0 is the first busy cycle).
    task automatic run_seq(input logic lvl, input int ign_at, input int rst_at,
                           input bit rec, input bit cmp, input bit dc);
        int   g, edges, last, first;
        logic prev, quiet;
        g     = int'(m_lfsr[2:0]) + 1;
        prev  = sw_a;
        edges = 0;
        last  = 0;
        first = -1;
        start_a = 1'b1;
        level_a = lvl;
        @(negedge clk);
        start_a = 1'b0;
        for (int s = 0; s <= 64; s++) begin
            if (sw_a !== prev) begin
                edges++;
                if (s < 64) begin
                    if (first < 0) begin
                        first = s;
                        check("first_toggle", s, g);
                    end else
                        check("gap_range", 32'((s - last >= 1) && (s - last <= 8)), 1);
                    last = s;
                end
            end
            prev = sw_a;
            if (rec) wave[s] = sw_a;
            if (cmp) check("repro_sw", sw_a, wave[s]);
            check("busy", busy_a, s < 64);
            check("done_tick", done_a, s == 64);
            if (s == rst_at) begin
                rst_a = 1'b1;
                @(negedge clk);
                check("mid_rst_sw", sw_a, 0);
                check("mid_rst_busy", busy_a, 0);
                check("mid_rst_done", done_a, 0);
                check("mid_rst_cnt", cnt_a, 0);
                @(negedge clk);
                rst_a = 1'b0;
                quiet = 1'b1;
                for (int i = 0; i < 70; i++) begin
                    if (done_a !== 1'b0 || busy_a !== 1'b0) quiet = 1'b0;
                    @(negedge clk);
                end
                check("aborted_quiet", quiet, 1);
                return;
            end
            start_a = (s == ign_at);
            level_a = (s == ign_at) ? !lvl : lvl;
            if (s < 64) @(negedge clk);
        end
        check("final_sw", sw_a, lvl);
        check("cnt_eq_edges", cnt_a, edges);
        check("multi_bounce", 32'(edges > 1), 1);
        if (dc) begin
            start_a = 1'b1;
            level_a = !lvl;
            @(negedge clk);
            check("start_on_done_ignored", busy_a, 0);
            check("done_one_cycle", done_a, 0);
            @(negedge clk);
            check("start_after_done", busy_a, 1);
            start_a = 1'b0;
            for (int i = 0; i < 100 && done_a !== 1'b1; i++) @(negedge clk);
            check("restart_done", done_a, 1);
            check("restart_sw", sw_a, !lvl);
        end else begin
            @(negedge clk);
            check("done_one_cycle", done_a, 0);
            check("idle_busy", busy_a, 0);
            check("hold_sw", sw_a, lvl);
            check("hold_cnt", cnt_a, edges);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   sb, edges_b;
        logic prev_b, mono;
        logic [7:0] pcnt;
        rst_a = 1'b1; start_a = 1'b0; level_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; level_b = 1'b0;
        @(negedge clk);
        check("rst_sw", sw_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cnt", cnt_a, 0);
        do_reset();
        check("idle_sw", sw_a, 0);
        run_seq(1'b1, -1, -1, 1, 0, 0);
        run_seq(1'b1, -1, -1, 0, 0, 0);
        do_reset();
        run_seq(1'b1, 9, -1, 0, 1, 0);
        do_reset();
        run_seq(1'b1, -1, 30, 0, 0, 0);
        do_reset();
        run_seq(1'b1, -1, -1, 0, 1, 0);
        run_seq(1'b0, -1, -1, 0, 0, 1);

        rst_b = 1'b0;
        @(negedge clk);
        prev_b  = sw_b;
        edges_b = 0;
        mono    = 1'b1;
        pcnt    = cnt_b;
        start_b = 1'b1;
        level_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (sb = 0; sb < 1100; sb++) begin
            if (sw_b !== prev_b) edges_b++;
            prev_b = sw_b;
            if (cnt_b < pcnt) mono = 1'b0;
            pcnt = cnt_b;
            if (done_b === 1'b1) break;
            @(negedge clk);
        end
        check("sat_done_cycle", sb, 1000);
        check("sat_cnt", cnt_b, 255);
        check("sat_no_wrap", mono, 1);
        check("sat_many_edges", 32'(edges_b > 255), 1);
        check("sat_final_sw", sw_b, 1);
        @(negedge clk);
        check("sat_hold_cnt", cnt_b, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
